// File: rtl/vga_timing_config.sv
// vga_timing_config: synchronises an asynchronous write strobe and decodes 4-bit commands
// into the VGA timing, pattern and colour registers.
// Optional macro VGA_CFG_SHADOW_EN: timing writes land in shadow registers and are copied
// to the active outputs at frame start. Without it, timing writes hit the outputs directly.
module vga_timing_config #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic [3:0]  cmd,
  input  logic [2:0]  data_hi,
  input  logic [7:0]  data_lo,
  input  logic        frame_start,
  output logic [11:0] hdisplay,
  output logic [9:0]  hfrontporch,
  output logic [9:0]  hsynclength,
  output logic [9:0]  hbackporch,
  output logic        hsyncpolarity,
  output logic [11:0] vdisplay,
  output logic [7:0]  vfrontporch,
  output logic [7:0]  vsynclength,
  output logic [7:0]  vbackporch,
  output logic        vsyncpolarity,
  output logic [4:0]  pattern,
  output logic [5:0]  color_in,
  output logic        pending
);

  typedef struct packed {
    logic [11:0] hdisp;
    logic [9:0]  hfp;
    logic [9:0]  hsl;
    logic [9:0]  hbp;
    logic        hpol;
    logic [11:0] vdisp;
    logic [7:0]  vfp;
    logic [7:0]  vsl;
    logic [7:0]  vbp;
    logic        vpol;
  } timing_t;

  localparam timing_t Preset = '{
    hdisp: 12'd640, hfp: 10'd16, hsl: 10'd96, hbp: 10'd48, hpol: 1'b0,
    vdisp: 12'd480, vfp: 8'd10,  vsl: 8'd2,   vbp: 8'd33,  vpol: 1'b0
  };

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_exec;

  // r_t is the set timing commands write: the shadow when double-buffered, else the outputs.
  timing_t    r_t, w_t, w_act;
  logic [4:0] r_pattern, w_pattern;
  logic [5:0] r_color, w_color;
  logic       w_twr;

  assign w_exec = r_sync[SYNC_STAGES-1] & ~r_hist;

  // Strobe synchroniser and edge-history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], strobe_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // Command decode: next values of the write target, pattern and colour.
  always_comb begin
    w_t       = r_t;
    w_pattern = r_pattern;
    w_color   = r_color;
    w_twr     = 1'b0;
    if (w_exec) begin
      unique case (cmd)
        4'd0, 4'd15: begin
          w_t       = Preset;
          w_pattern = 5'd31;
          w_color   = 6'd0;
          w_twr     = 1'b1;
        end
        4'd1:  w_pattern = r_pattern + 5'd1;
        4'd2:  w_pattern = r_pattern - 5'd1;
        4'd3:  w_pattern = data_lo[4:0];
        4'd4:  begin w_t.hdisp = {1'b0, data_hi, data_lo};  w_twr = 1'b1; end
        4'd5:  begin w_t.hfp   = {data_hi[1:0], data_lo};   w_twr = 1'b1; end
        4'd6:  begin
          w_t.hsl  = {data_hi[1:0], data_lo};
          w_t.hpol = data_hi[2];
          w_twr    = 1'b1;
        end
        4'd7:  begin w_t.hbp   = {data_hi[1:0], data_lo};   w_twr = 1'b1; end
        4'd8:  begin w_t.vdisp = {1'b0, data_hi, data_lo};  w_twr = 1'b1; end
        4'd9:  begin w_t.vfp   = data_lo;                   w_twr = 1'b1; end
        4'd10: begin
          w_t.vsl  = data_lo;
          w_t.vpol = data_hi[2];
          w_twr    = 1'b1;
        end
        4'd11: begin w_t.vbp   = data_lo;                   w_twr = 1'b1; end
        4'd12: w_color = data_lo[5:0];
        4'd13: w_color = r_color + 6'd1;
        4'd14: w_color = r_color - 6'd1;
        default: ;
      endcase
    end
  end

  // Write-target timing, pattern and colour registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t       <= Preset;
      r_pattern <= 5'd31;
      r_color   <= 6'd0;
    end else begin
      r_t       <= w_t;
      r_pattern <= w_pattern;
      r_color   <= w_color;
    end
  end

`ifdef VGA_CFG_SHADOW_EN
  timing_t r_a;
  logic    r_pending;

  // Active timing: commit copies the pre-write shadow; a same-cycle write keeps pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= Preset;
      r_pending <= 1'b0;
    end else begin
      if (frame_start && r_pending) begin
        r_a       <= r_t;
        r_pending <= 1'b0;
      end
      if (w_twr) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_act   = r_a;
  assign pending = r_pending;
`else
  logic w_unused_sigs;
  assign w_unused_sigs = frame_start ^ w_twr;
  assign w_act         = r_t;
  assign pending       = 1'b0;
`endif

  assign hdisplay      = w_act.hdisp;
  assign hfrontporch   = w_act.hfp;
  assign hsynclength   = w_act.hsl;
  assign hbackporch    = w_act.hbp;
  assign hsyncpolarity = w_act.hpol;
  assign vdisplay      = w_act.vdisp;
  assign vfrontporch   = w_act.vfp;
  assign vsynclength   = w_act.vsl;
  assign vbackporch    = w_act.vbp;
  assign vsyncpolarity = w_act.vpol;
  assign pattern       = r_pattern;
  assign color_in      = r_color;

endmodule

// File: tb/tb_vga_timing_config.sv
// Self-checking bench for vga_timing_config: directed steps from the test plan followed by
// random commands, all compared against an arithmetic model of the command set.
module tb_vga_timing_config;

`ifdef VGA_CFG_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, strobe_in, frame_start;
  logic [3:0]  cmd;
  logic [2:0]  data_hi;
  logic [7:0]  data_lo;
  logic [11:0] hdisplay, vdisplay;
  logic [9:0]  hfrontporch, hsynclength, hbackporch;
  logic [7:0]  vfrontporch, vsynclength, vbackporch;
  logic        hsyncpolarity, vsyncpolarity, pending;
  logic [4:0]  pattern;
  logic [5:0]  color_in;

  vga_timing_config #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .strobe_in(strobe_in), .cmd(cmd), .data_hi(data_hi),
    .data_lo(data_lo), .frame_start(frame_start), .hdisplay(hdisplay),
    .hfrontporch(hfrontporch), .hsynclength(hsynclength), .hbackporch(hbackporch),
    .hsyncpolarity(hsyncpolarity), .vdisplay(vdisplay), .vfrontporch(vfrontporch),
    .vsynclength(vsynclength), .vbackporch(vbackporch), .vsyncpolarity(vsyncpolarity),
    .pattern(pattern), .color_in(color_in), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hd, hfp, hsl, hbp, hp, vd, vfp, vsl, vbp, vp;
  } tm_t;

  tm_t m_sh, m_act;
  int  m_pat, m_col, m_pend;
  int  checks = 0;
  int  errors = 0;

  function automatic tm_t preset();
    tm_t t;
    t.hd = 640; t.hfp = 16; t.hsl = 96; t.hbp = 48; t.hp = 0;
    t.vd = 480; t.vfp = 10; t.vsl = 2;  t.vbp = 33; t.vp = 0;
    return t;
  endfunction

  task automatic model_reset();
    m_sh = preset(); m_act = preset(); m_pat = 31; m_col = 0; m_pend = 0;
  endtask

  task automatic model_frame();
    if (m_pend != 0) begin
      m_act  = m_sh;
      m_pend = 0;
    end
  endtask

  task automatic model_exec(input int c, input int hi, input int lo);
    bit tw = 1'b1;
    case (c)
      0, 15: begin m_sh = preset(); m_pat = 31; m_col = 0; end
      1:  begin m_pat = (m_pat + 1) % 32;  tw = 1'b0; end
      2:  begin m_pat = (m_pat + 31) % 32; tw = 1'b0; end
      3:  begin m_pat = lo % 32;           tw = 1'b0; end
      4:  m_sh.hd  = hi * 256 + lo;
      5:  m_sh.hfp = (hi % 4) * 256 + lo;
      6:  begin m_sh.hsl = (hi % 4) * 256 + lo; m_sh.hp = hi / 4; end
      7:  m_sh.hbp = (hi % 4) * 256 + lo;
      8:  m_sh.vd  = hi * 256 + lo;
      9:  m_sh.vfp = lo;
      10: begin m_sh.vsl = lo; m_sh.vp = hi / 4; end
      11: m_sh.vbp = lo;
      12: begin m_col = lo % 64;        tw = 1'b0; end
      13: begin m_col = (m_col + 1) % 64;  tw = 1'b0; end
      default: begin m_col = (m_col + 63) % 64; tw = 1'b0; end
    endcase
    if (tw) begin
      if (Shadow) m_pend = 1;
      else        m_act  = m_sh;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/hdisplay"},      {20'd0, hdisplay},      m_act.hd);
    chk({tag, "/hfrontporch"},   {22'd0, hfrontporch},   m_act.hfp);
    chk({tag, "/hsynclength"},   {22'd0, hsynclength},   m_act.hsl);
    chk({tag, "/hbackporch"},    {22'd0, hbackporch},    m_act.hbp);
    chk({tag, "/hsyncpolarity"}, {31'd0, hsyncpolarity}, m_act.hp);
    chk({tag, "/vdisplay"},      {20'd0, vdisplay},      m_act.vd);
    chk({tag, "/vfrontporch"},   {24'd0, vfrontporch},   m_act.vfp);
    chk({tag, "/vsynclength"},   {24'd0, vsynclength},   m_act.vsl);
    chk({tag, "/vbackporch"},    {24'd0, vbackporch},    m_act.vbp);
    chk({tag, "/vsyncpolarity"}, {31'd0, vsyncpolarity}, m_act.vp);
    chk({tag, "/pattern"},       {27'd0, pattern},       m_pat);
    chk({tag, "/color_in"},      {26'd0, color_in},      m_col);
    chk({tag, "/pending"},       {31'd0, pending},       m_pend);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; strobe_in = 1'b0; frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  // Raise the strobe, confirm nothing moves before the 3rd edge, optionally pulse
  // frame_start on the execute edge, hold the strobe, then release and let it settle.
  task automatic send(input int c, input int hi, input int lo, input bit fs, input int hold,
                      input string tag);
    @(negedge clk);
    cmd = c[3:0]; data_hi = hi[2:0]; data_lo = lo[7:0]; strobe_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check_all({tag, "/early"});
    @(negedge clk);
    frame_start = fs;
    @(posedge clk);
    #1;
    if (fs) model_frame();
    model_exec(c, hi, lo);
    check_all({tag, "/exec"});
    @(negedge clk);
    frame_start = 1'b0;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_all({tag, "/held"});
    end
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_pulse(input string tag);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 model_frame();
    check_all(tag);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; strobe_in = 1'b0; frame_start = 1'b0;
    cmd = 4'd0; data_hi = 3'd0; data_lo = 8'd0;
    model_reset();

    do_reset("reset");
    chk("reset_hdisplay_640", {20'd0, hdisplay}, 640);

    // Latency and no-repeat while held high.
    send(12, 0, 8'h2A, 1'b0, 20, "latency");
    chk("latency_color_2a", {26'd0, color_in}, 42);

    // Shadow commit of hdisplay = 800.
    send(4, 3, 8'h20, 1'b0, 0, "hdisp800");
    frame_pulse("hdisp_commit");
    chk("hdisp_800", {20'd0, hdisplay}, 800);

    // Wraps.
    send(1, 0, 0, 1'b0, 0, "pat_wrap");
    chk("pattern_wrap_0", {27'd0, pattern}, 0);
    send(12, 0, 0, 1'b0, 0, "color_zero");
    send(14, 0, 0, 1'b0, 0, "color_wrap");
    chk("color_wrap_63", {26'd0, color_in}, 63);
    send(2, 0, 0, 1'b0, 0, "pat_dec_wrap");
    send(13, 0, 0, 1'b0, 0, "color_inc_wrap");
    send(6, 4, 8'h60, 1'b0, 0, "hsync_pol");
    frame_pulse("hsync_commit");

    // Commit on the same edge as a write, then the later value at the next frame.
    send(9, 0, 11, 1'b0, 0, "vfp11");
    send(9, 0, 12, 1'b1, 0, "collision");
    frame_pulse("collision_commit");
    chk("vfp_12", {24'd0, vfrontporch}, 12);
    frame_pulse("idle_frame");

    // Reset with a pending vdisplay write.
    send(8, 2, 8'h58, 1'b0, 0, "vdisp600");
    do_reset("mid_reset");
    chk("mid_reset_vdisp_480", {20'd0, vdisplay}, 480);

    // Random commands, data and frame_start timing.
    for (int i = 0; i < 60; i++) begin
      int c, hi, lo, h;
      bit fs;
      c  = $urandom_range(0, 15);
      hi = $urandom_range(0, 7);
      lo = $urandom_range(0, 255);
      fs = ($urandom_range(0, 3) == 0);
      h  = $urandom_range(0, 2);
      send(c, hi, lo, fs, h, $sformatf("rnd%0d_c%0d", i, c));
      if ($urandom_range(0, 2) == 0) frame_pulse($sformatf("rnd%0d_frame", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_config.md
Name: vga_timing_config

Overview:
- Configuration front-end that sits directly upstream of hvsync_generator and pattern_generator.
- Synchronises an asynchronous write strobe into clk and decodes 4-bit commands into the VGA timing, pattern and colour registers that feed those stages.
- Timing writes go to shadow registers and commit atomically at frame start, so the sync generator never sees a half-updated mode mid-frame.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the strobe synchroniser (minimum 2).

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
strobe_in  input  1  asynchronous write strobe; a rising edge issues one command
cmd  input  4  command code, quasi-static around the strobe
data_hi  input  3  upper data bits (bit 2 doubles as the polarity bit)
data_lo  input  8  lower data byte
frame_start  input  1  single-cycle pulse from the sync generator at hpos=0, vpos=0
hdisplay  output  12  active horizontal pixels
hfrontporch  output  10  horizontal front porch
hsynclength  output  10  horizontal sync width
hbackporch  output  10  horizontal back porch
hsyncpolarity  output  1  1 = active-high hsync
vdisplay  output  12  active lines
vfrontporch  output  8  vertical front porch
vsynclength  output  8  vertical sync width
vbackporch  output  8  vertical back porch
vsyncpolarity  output  1  1 = active-high vsync
pattern  output  5  pattern select
color_in  output  6  base colour RRGGBB
pending  output  1  shadow timing differs from active, awaiting commit

Behaviour:
- Reset and preset values, applied to both shadow and active registers:
  - Horizontal: hdisplay 640, hfrontporch 16, hsynclength 96, hbackporch 48, hsyncpolarity 0.
  - Vertical: vdisplay 480, vfrontporch 10, vsynclength 2, vbackporch 33, vsyncpolarity 0.
  - pattern 31, color_in 0, pending 0.
  - Synchroniser chain and edge-history flop cleared to 0.
- Reset mid-operation discards any pending shadow contents.
- Edge detect: edge = sync[SYNC_STAGES-1] & ~hist. One command executes per rising edge of strobe_in. Holding strobe_in high produces no repeats.
- Latency: the command executes on the (SYNC_STAGES+1)th rising clk edge at which strobe_in is sampled high; this is the 3rd edge at default.
- cmd and data are not synchronised. They are sampled at the execute edge and must be stable from strobe rise through that edge.
- Command decode ({a,b} denotes concatenation):
  - 0 or 15: preset. Loads preset values into the shadow timing registers and, immediately, into pattern and color_in.
  - 1: pattern+1, wrapping 31->0.
  - 2: pattern-1, wrapping 0->31.
  - 3: pattern = data_lo[4:0].
  - 4: shadow hdisplay = {0,data_hi,data_lo}.
  - 5: shadow hfrontporch = {data_hi[1:0],data_lo}.
  - 6: shadow hsynclength = {data_hi[1:0],data_lo}; shadow hsyncpolarity = data_hi[2].
  - 7: shadow hbackporch = {data_hi[1:0],data_lo}.
  - 8: shadow vdisplay = {0,data_hi,data_lo}.
  - 9: shadow vfrontporch = data_lo.
  - 10: shadow vsynclength = data_lo; shadow vsyncpolarity = data_hi[2].
  - 11: shadow vbackporch = data_lo.
  - 12: color_in = data_lo[5:0].
  - 13: color_in+1, wrapping 63->0.
  - 14: color_in-1, wrapping 0->63.
- pattern and color_in update at the execute edge. They are not shadowed.
- pending:
  - Set at the execute edge of any command that writes a shadow timing register (0, 4-11, 15), even if the value is unchanged.
  - Cleared on commit.
- Commit: on any clk edge with frame_start=1 and pending=1, all ten active timing outputs take the shadow values.
- frame_start with pending=0 has no effect.
- Simultaneous execute and frame_start in the same cycle:
  - The commit copies the shadow values from before this cycle's write.
  - The write then lands in the shadow, and pending remains 1.
  - The new value commits at the next frame_start.
- Every output is a flop. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro VGA_CFG_SHADOW_EN.
- Defined: double-buffered commit exactly as described above.
- Not defined:
  - Shadow registers are not built.
  - Timing commands write the active registers directly at the execute edge.
  - frame_start is ignored, and pending is tied to 0.

Test Plan:
- Reset: assert reset for 2 cycles -> hdisplay=640, vbackporch=33, pattern=31, color_in=0, pending=0.
- Latency: strobe rises with cmd=12, data_lo=0x2A -> color_in=0x2A after exactly the 3rd clk edge, not earlier; strobe held high 20 cycles -> single update.
- Shadow commit: cmd=4, data_hi=3, data_lo=0x20 -> pending=1, hdisplay stays 640; pulse frame_start -> hdisplay=800, pending=0.
- Wrap: with pattern=31, cmd=1 -> 0; with color_in=0, cmd=14 -> 63; cmd=6, data_hi=4, data_lo=0x60, then commit -> hsynclength=96, hsyncpolarity=1.
- Collision: the cmd=9, data_lo=12 execute edge coincides with frame_start while earlier shadow vfrontporch=11 is pending -> vfrontporch=11, pending=1; next frame_start -> 12.
- Reset mid-operation: pending write of vdisplay=600, then reset before frame_start -> vdisplay=480, pending=0; without VGA_CFG_SHADOW_EN, the vdisplay write is visible at the execute edge.
